regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DEPTH, default 32, number of registers (power of 2, >=4).
REQ-002 SHALL have parameter DATA_WIDTH, default 64, register width (multiple of 8).
REQ-003 SHALL have parameter NUM_RD, default 2, read port count (1..8).
REQ-004 SHALL have parameter NUM_WR, default 2, write port count (1..4).
REQ-005 SHALL have parameter RD_REG, default 0, 0 = asynchronous read, 1 = registered read (1-cycle latency).
REQ-006 SHALL have parameter ZERO_R0, default 1, 1 = R0 reads 0 and ignores writes and reserves.
REQ-007 SHALL have derived parameter ADDR_WIDTH = $clog2(DEPTH) and BE_WIDTH = DATA_WIDTH/8.
REQ-008 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-009 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-010 SHALL have port wrEn  input  NUM_WR  per-port write enable.
REQ-011 SHALL have port wrAddr  input  NUM_WR*ADDR_WIDTH  packed write addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-012 SHALL have port wrByteEn  input  NUM_WR*BE_WIDTH  packed per-byte write enables.
REQ-013 SHALL have port dataIn  input  NUM_WR*DATA_WIDTH  packed write data.
REQ-014 SHALL have port rdAddr  input  NUM_RD*ADDR_WIDTH  packed read addresses.
REQ-015 SHALL have port dataOut  output  NUM_RD*DATA_WIDTH  packed read data.
REQ-016 SHALL have port rdBusy  output  NUM_RD  scoreboard busy flag of the addressed register.
REQ-017 SHALL have port rsvEn  input  1  reserve (mark pending) request.
REQ-018 SHALL have port rsvAddr  input  ADDR_WIDTH  register to reserve.
REQ-019 SHALL have port busyVec  output  DEPTH  registered scoreboard bits, bit i = register i pending.

Function
REQ-020 SHALL update each byte b of regFile[wrAddr k] with dataIn byte b on the clk edge when wrEn[k] and wrByteEn[k][b] are both 1; other bytes hold.
REQ-021 SHALL resolve same-address writes from several ports per byte, highest-numbered port with that byte enabled winning.
REQ-022 SHALL ignore writes to address 0 when ZERO_R0=1; dataOut for address 0 SHALL then be 0 regardless of bypass.
REQ-023 SHALL, with RD_REG=0, drive dataOut[i] combinationally: stored word with enabled bytes of same-cycle writes to rdAddr[i] merged in (bypass, same priority as REQ-021).
REQ-024 SHALL, with RD_REG=1, register the REQ-023 value at the clk edge, so dataOut/rdBusy correspond to the rdAddr of the previous cycle.
REQ-025 SHALL set busyVec[rsvAddr] at the clk edge when rsvEn=1 (ignored for address 0 when ZERO_R0=1).
REQ-026 SHALL clear busyVec[a] at the clk edge when any port writes address a with any byte enabled, unless rsvEn=1 with rsvAddr=a in the same cycle (reserve wins).
REQ-027 SHALL drive rdBusy[i] = busyVec[rdAddr i] AND NOT (same-cycle write to rdAddr i), registered per REQ-024 when RD_REG=1.
REQ-028 SHALL treat a write with wrEn=1 but all byte enables 0 as no write (no data change, no busy clear, no bypass).
REQ-029 SHALL produce no X on outputs for any in-range address; all read ports SHALL be independent and may alias.

Reset
REQ-030 SHALL, while reset=0, asynchronously clear all registers, busyVec, and (RD_REG=1) the dataOut/rdBusy output registers to 0.
REQ-031 SHALL, while reset=0, ignore wrEn and rsvEn; with RD_REG=0 dataOut SHALL read 0 (no bypass during reset).
REQ-032 SHALL resume normal operation on the first clk edge after reset deasserts; a reset mid-write SHALL leave the target register 0.

Verification
REQ-033 SHALL cover: reset, write R5=0x1122334455667788 all bytes, next cycle read R5 on both ports -> both dataOut = 0x1122334455667788 (RD_REG=0).
REQ-034 SHALL cover: R5 holds 0x1122334455667788, port0 wrByteEn=0x0F dataIn=0xAAAAAAAAAAAAAAAA, port1 same addr wrByteEn=0x03 dataIn=0xBBBB..BB -> same-cycle bypass and later read = 0x11223344AAAABBBB.
REQ-035 SHALL cover: write 0xFFFF..FF to R0 with reserve R0 -> dataOut for R0 = 0, busyVec[0] = 0 (ZERO_R0=1).
REQ-036 SHALL cover: rsvEn R7 -> busyVec[7]=1, rdBusy for R7 = 1; write R7 -> rdBusy=0 same cycle, busyVec[7]=0 next; write and reserve R7 same cycle -> busyVec[7] stays 1.
REQ-037 SHALL cover: RD_REG=1, rdAddr=R3 in cycle N while writing R3=0x42 -> dataOut=0x42 in cycle N+1.
REQ-038 SHALL cover: reset asserted between clk edges with R9 written and busy -> dataOut, busyVec immediately 0 without a clk edge.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file with per-byte write enables, write bypass,
// a pending-write scoreboard (reserve / clear-on-write) and an optional
// registered read stage.
//
// Ports:
//   clk, reset   single rising-edge clock, async active-low reset
//   wrEn         per write port enable
//   wrAddr       packed write addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   wrByteEn     packed per-byte enables, port k at [k*BE_WIDTH +: BE_WIDTH]
//   dataIn       packed write data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   rdAddr       packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   dataOut      packed read data (bypassed; registered when RD_REG=1)
//   rdBusy       pending flag of each addressed register, masked by
//                a same-cycle write to that register
//   rsvEn        reserve request, marks rsvAddr pending
//   rsvAddr      register to reserve
//   busyVec      registered scoreboard, bit i = register i pending
module regfile_mp #(
  parameter int DEPTH      = 32,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2,
  parameter int RD_REG     = 0,
  parameter int ZERO_R0    = 1,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_WR-1:0]              wrEn,
  input  logic [NUM_WR*ADDR_WIDTH-1:0]   wrAddr,
  input  logic [NUM_WR*BE_WIDTH-1:0]     wrByteEn,
  input  logic [NUM_WR*DATA_WIDTH-1:0]   dataIn,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   rdAddr,
  output logic [NUM_RD*DATA_WIDTH-1:0]   dataOut,
  output logic [NUM_RD-1:0]              rdBusy,
  input  logic                           rsvEn,
  input  logic [ADDR_WIDTH-1:0]          rsvAddr,
  output logic [DEPTH-1:0]               busyVec
);

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [BE_WIDTH-1:0]   be_t;

  word_t mem_q [DEPTH];
  word_t mem_d [DEPTH];
  logic [DEPTH-1:0] wr_hit;
  logic [DEPTH-1:0] busy_d;

  addr_t wa    [NUM_WR];
  word_t wd    [NUM_WR];
  be_t   wb_en [NUM_WR];

  addr_t ra   [NUM_RD];
  word_t rv   [NUM_RD];
  logic  rhit [NUM_RD];

  logic [NUM_RD*DATA_WIDTH-1:0] rd_data_c;
  logic [NUM_RD-1:0]            rd_busy_c;
  logic                         rsv_ok;

  // Unpack write ports; a disabled port contributes no byte enables,
  // so every consumer below only needs to look at wb_en.
  for (genvar k = 0; k < NUM_WR; k++) begin : g_wr
    assign wa[k]    = wrAddr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign wd[k]    = dataIn[k*DATA_WIDTH +: DATA_WIDTH];
    assign wb_en[k] = wrEn[k] ? wrByteEn[k*BE_WIDTH +: BE_WIDTH] : '0;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    assign ra[i] = rdAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign rd_data_c[i*DATA_WIDTH +: DATA_WIDTH] = rv[i];
  end

  // Next register state. Ports are visited in ascending order, so a
  // higher port overrides a lower one byte by byte.
  always_comb begin
    for (int a = 0; a < DEPTH; a++) begin
      mem_d[a]  = mem_q[a];
      wr_hit[a] = 1'b0;
      for (int k = 0; k < NUM_WR; k++) begin
        if (wa[k] == addr_t'(a)) begin
          for (int b = 0; b < BE_WIDTH; b++) begin
            if (wb_en[k][b]) begin
              mem_d[a][b*8 +: 8] = wd[k][b*8 +: 8];
              wr_hit[a]          = 1'b1;
            end
          end
        end
      end
    end
    if (ZERO_R0 != 0) begin
      mem_d[0]  = '0;
      wr_hit[0] = 1'b0;
    end
  end

  assign rsv_ok = rsvEn && !((ZERO_R0 != 0) && (rsvAddr == '0));

  // Reserve takes priority over a same-cycle clearing write.
  always_comb begin
    busy_d = busyVec & ~wr_hit;
    if (rsv_ok) begin
      busy_d[rsvAddr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int a = 0; a < DEPTH; a++) begin
        mem_q[a] <= '0;
      end
      busyVec <= '0;
    end else begin
      for (int a = 0; a < DEPTH; a++) begin
        mem_q[a] <= mem_d[a];
      end
      busyVec <= busy_d;
    end
  end

  // Read path: stored word with same-cycle written bytes merged in.
  // Output is forced to 0 while reset is low so nothing bypasses.
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rv[i]   = mem_q[ra[i]];
      rhit[i] = 1'b0;
      for (int k = 0; k < NUM_WR; k++) begin
        if (wa[k] == ra[i]) begin
          for (int b = 0; b < BE_WIDTH; b++) begin
            if (wb_en[k][b]) begin
              rv[i][b*8 +: 8] = wd[k][b*8 +: 8];
              rhit[i]         = 1'b1;
            end
          end
        end
      end
      if ((ZERO_R0 != 0) && (ra[i] == '0)) begin
        rv[i]   = '0;
        rhit[i] = 1'b0;
      end
      if (!reset) begin
        rv[i] = '0;
      end
      rd_busy_c[i] = busyVec[ra[i]] & ~rhit[i] & reset;
    end
  end

  if (RD_REG != 0) begin : g_rd_reg
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        dataOut <= '0;
        rdBusy  <= '0;
      end else begin
        dataOut <= rd_data_c;
        rdBusy  <= rd_busy_c;
      end
    end
  end else begin : g_rd_comb
    assign dataOut = rd_data_c;
    assign rdBusy  = rd_busy_c;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one combinational-read and one
// registered-read instance share the same stimulus.
module tb_regfile_mp;

  localparam int AW = 5;
  localparam int DW = 64;

  logic          clk;
  logic          reset;
  logic [1:0]    wrEn;
  logic [9:0]    wrAddr;
  logic [15:0]   wrByteEn;
  logic [127:0]  dataIn;
  logic [9:0]    rdAddr;
  logic          rsvEn;
  logic [4:0]    rsvAddr;

  logic [127:0]  dataOut0;
  logic [1:0]    rdBusy0;
  logic [31:0]   busyVec0;
  logic [127:0]  dataOut1;
  logic [1:0]    rdBusy1;
  logic [31:0]   busyVec1;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_mp #(.RD_REG(0)) u_comb (
    .clk(clk), .reset(reset), .wrEn(wrEn), .wrAddr(wrAddr),
    .wrByteEn(wrByteEn), .dataIn(dataIn), .rdAddr(rdAddr),
    .dataOut(dataOut0), .rdBusy(rdBusy0), .rsvEn(rsvEn),
    .rsvAddr(rsvAddr), .busyVec(busyVec0)
  );

  regfile_mp #(.RD_REG(1)) u_reg (
    .clk(clk), .reset(reset), .wrEn(wrEn), .wrAddr(wrAddr),
    .wrByteEn(wrByteEn), .dataIn(dataIn), .rdAddr(rdAddr),
    .dataOut(dataOut1), .rdBusy(rdBusy1), .rsvEn(rsvEn),
    .rsvAddr(rsvAddr), .busyVec(busyVec1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    wrEn     = '0;
    wrAddr   = '0;
    wrByteEn = '0;
    dataIn   = '0;
    rsvEn    = 1'b0;
    rsvAddr  = '0;
  endtask

  task automatic wr(input int k, input logic [4:0] a,
                    input logic [7:0] be, input logic [63:0] d);
    wrEn[k]               = 1'b1;
    wrAddr[k*AW +: AW]    = a;
    wrByteEn[k*8 +: 8]    = be;
    dataIn[k*DW +: DW]    = d;
  endtask

  task automatic rd(input int i, input logic [4:0] a);
    rdAddr[i*AW +: AW] = a;
  endtask

  task automatic rsv(input logic [4:0] a);
    rsvEn   = 1'b1;
    rsvAddr = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    rdAddr = '0;
    idle();
    wr(0, 5'd1, 8'hFF, 64'hDEADBEEF_CAFEF00D);
    rsv(5'd1);
    rd(0, 5'd1);
    @(negedge clk);
    n_checks++;
    if (dataOut0[63:0] !== 64'h0) begin
      $display("FAIL reset_no_bypass got %h exp 0", dataOut0[63:0]);
      n_fail++;
    end
    n_checks++;
    if (busyVec0 !== 32'h0 || rdBusy0 !== 2'b00) begin
      $display("FAIL reset_busy got %h/%b exp 0", busyVec0, rdBusy0);
      n_fail++;
    end
    n_checks++;
    if (dataOut1 !== 128'h0 || rdBusy1 !== 2'b00) begin
      $display("FAIL reset_regout got %h exp 0", dataOut1);
      n_fail++;
    end
    idle();
    reset = 1'b1;
    step();
    @(negedge clk);
    n_checks++;
    if (dataOut0[63:0] !== 64'h0 || busyVec0 !== 32'h0) begin
      $display("FAIL reset_ignored_wr got %h/%h exp 0",
               dataOut0[63:0], busyVec0);
      n_fail++;
    end
  endtask

  task automatic test_full_write();
    step();
    idle();
    wr(0, 5'd5, 8'hFF, 64'h1122334455667788);
    rd(0, 5'd5);
    rd(1, 5'd5);
    @(negedge clk);
    n_checks++;
    if (dataOut0 !== {2{64'h1122334455667788}}) begin
      $display("FAIL full_bypass got %h exp %h", dataOut0,
               {2{64'h1122334455667788}});
      n_fail++;
    end
    step();
    idle();
    @(negedge clk);
    n_checks++;
    if (dataOut0 !== {2{64'h1122334455667788}}) begin
      $display("FAIL full_read got %h exp %h", dataOut0,
               {2{64'h1122334455667788}});
      n_fail++;
    end
  endtask

  task automatic test_byte_merge();
    step();
    idle();
    wr(0, 5'd5, 8'h0F, 64'hAAAAAAAAAAAAAAAA);
    wr(1, 5'd5, 8'h03, 64'hBBBBBBBBBBBBBBBB);
    rd(0, 5'd5);
    rd(1, 5'd5);
    @(negedge clk);
    n_checks++;
    if (dataOut0 !== {2{64'h11223344AAAABBBB}}) begin
      $display("FAIL merge_bypass got %h exp %h", dataOut0,
               {2{64'h11223344AAAABBBB}});
      n_fail++;
    end
    step();
    idle();
    @(negedge clk);
    n_checks++;
    if (dataOut0[127:64] !== 64'h11223344AAAABBBB) begin
      $display("FAIL merge_read got %h exp 11223344aaaabbbb",
               dataOut0[127:64]);
      n_fail++;
    end
  endtask

  task automatic test_r0();
    step();
    idle();
    wr(0, 5'd0, 8'hFF, 64'hFFFFFFFFFFFFFFFF);
    rsv(5'd0);
    rd(0, 5'd0);
    rd(1, 5'd5);
    @(negedge clk);
    n_checks++;
    if (dataOut0[63:0] !== 64'h0 || rdBusy0[0] !== 1'b0) begin
      $display("FAIL r0_bypass got %h/%b exp 0/0",
               dataOut0[63:0], rdBusy0[0]);
      n_fail++;
    end
    step();
    idle();
    @(negedge clk);
    n_checks++;
    if (dataOut0[63:0] !== 64'h0 || busyVec0[0] !== 1'b0) begin
      $display("FAIL r0_after got %h/%b exp 0/0",
               dataOut0[63:0], busyVec0[0]);
      n_fail++;
    end
  endtask

  task automatic test_scoreboard();
    step();
    idle();
    rsv(5'd7);
    rd(0, 5'd7);
    @(negedge clk);
    n_checks++;
    if (rdBusy0[0] !== 1'b0) begin
      $display("FAIL rsv_same_cycle got %b exp 0", rdBusy0[0]);
      n_fail++;
    end
    step();
    idle();
    @(negedge clk);
    n_checks++;
    if (busyVec0[7] !== 1'b1 || rdBusy0[0] !== 1'b1) begin
      $display("FAIL rsv_set got %b/%b exp 1/1", busyVec0[7], rdBusy0[0]);
      n_fail++;
    end
    step();
    idle();
    wr(1, 5'd7, 8'h01, 64'h55);
    @(negedge clk);
    n_checks++;
    if (rdBusy0[0] !== 1'b0 || busyVec0[7] !== 1'b1) begin
      $display("FAIL wr_mask got %b/%b exp 0/1", rdBusy0[0], busyVec0[7]);
      n_fail++;
    end
    step();
    idle();
    @(negedge clk);
    n_checks++;
    if (busyVec0[7] !== 1'b0 || dataOut0[63:0] !== 64'h55) begin
      $display("FAIL wr_clear got %b/%h exp 0/55",
               busyVec0[7], dataOut0[63:0]);
      n_fail++;
    end
    step();
    idle();
    rsv(5'd7);
    step();
    idle();
    wr(0, 5'd7, 8'h01, 64'h66);
    rsv(5'd7);
    @(negedge clk);
    n_checks++;
    if (rdBusy0[0] !== 1'b0) begin
      $display("FAIL wr_rsv_mask got %b exp 0", rdBusy0[0]);
      n_fail++;
    end
    step();
    idle();
    wr(0, 5'd7, 8'h00, 64'hFFFFFFFFFFFFFFFF);
    @(negedge clk);
    n_checks++;
    if (busyVec0[7] !== 1'b1 || rdBusy0[0] !== 1'b1 ||
        dataOut0[63:0] !== 64'h66) begin
      $display("FAIL rsv_wins got %b/%b/%h exp 1/1/66",
               busyVec0[7], rdBusy0[0], dataOut0[63:0]);
      n_fail++;
    end
    step();
    idle();
    @(negedge clk);
    n_checks++;
    if (busyVec0[7] !== 1'b1 || dataOut0[63:0] !== 64'h66) begin
      $display("FAIL zero_be got %b/%h exp 1/66",
               busyVec0[7], dataOut0[63:0]);
      n_fail++;
    end
  endtask

  task automatic test_rd_reg();
    step();
    idle();
    wr(0, 5'd3, 8'hFF, 64'h42);
    rd(0, 5'd3);
    rd(1, 5'd5);
    @(negedge clk);
    n_checks++;
    if (dataOut0[63:0] !== 64'h42) begin
      $display("FAIL rdreg_comb got %h exp 42", dataOut0[63:0]);
      n_fail++;
    end
    step();
    idle();
    rd(0, 5'd0);
    rd(1, 5'd0);
    @(negedge clk);
    n_checks++;
    if (dataOut1[63:0] !== 64'h42 ||
        dataOut1[127:64] !== 64'h11223344AAAABBBB) begin
      $display("FAIL rdreg_lat got %h exp 11223344aaaabbbb_42", dataOut1);
      n_fail++;
    end
    n_checks++;
    if (dataOut0 !== 128'h0) begin
      $display("FAIL rdreg_addr0 got %h exp 0", dataOut0);
      n_fail++;
    end
  endtask

  task automatic test_async_reset();
    step();
    idle();
    wr(0, 5'd9, 8'hFF, 64'h0123456789ABCDEF);
    rsv(5'd9);
    rd(0, 5'd9);
    rd(1, 5'd9);
    step();
    idle();
    @(negedge clk);
    n_checks++;
    if (dataOut0[63:0] !== 64'h0123456789ABCDEF || busyVec0[9] !== 1'b1 ||
        dataOut1[63:0] !== 64'h0123456789ABCDEF) begin
      $display("FAIL pre_reset got %h/%b/%h exp 0123456789abcdef/1",
               dataOut0[63:0], busyVec0[9], dataOut1[63:0]);
      n_fail++;
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (dataOut0 !== 128'h0 || busyVec0 !== 32'h0 ||
        dataOut1 !== 128'h0 || busyVec1 !== 32'h0 ||
        rdBusy1 !== 2'b00) begin
      $display("FAIL async_reset got %h/%h/%h exp 0",
               dataOut0, busyVec0, dataOut1);
      n_fail++;
    end
    wr(0, 5'd9, 8'hFF, 64'hFFFF0000FFFF0000);
    step();
    reset = 1'b1;
    idle();
    @(negedge clk);
    n_checks++;
    if (dataOut0[63:0] !== 64'h0 || busyVec0 !== 32'h0) begin
      $display("FAIL reset_mid_write got %h/%h exp 0",
               dataOut0[63:0], busyVec0);
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_full_write();
    test_byte_merge();
    test_r0();
    test_scoreboard();
    test_rd_reg();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
